alarm_qsys_onchip_memory_dp: RTL and testbench
==============================================

ALARM_QSYS_ONCHIP_MEMORY_DP -- requirements
Module: alarm_qsys_onchip_memory_dp

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits (multiple of 8, 8..128).
REQ-002 SHALL have parameter DEPTH, default 3072, number of words.
REQ-003 SHALL have parameter ADDR_WIDTH, default 12, port address width; SHALL satisfy 2**ADDR_WIDTH >= DEPTH.
REQ-004 SHALL have parameter INIT_FILE, default "alarm_qsys_onchip_memory_dp.hex", power-up contents.
REQ-005 SHALL have one clock and an asynchronous active-low reset: clk  in  1  sole clock, rising-edge.
REQ-006 reset_n  in  1  asynchronous active-low reset.
REQ-007 reset_req  in  1  pending-reset request; both ports behave as clken low while it is high.
REQ-008 s1_address, s2_address  in  ADDR_WIDTH  word address per port.
REQ-009 s1_chipselect, s1_read, s1_write, s1_clken (likewise s2_*)  in  1  per-port access strobes and clock enable.
REQ-010 s1_byteenable, s2_byteenable  in  DATA_WIDTH/8  byte-lane write mask.
REQ-011 s1_writedata, s2_writedata  in  DATA_WIDTH  write data.
REQ-012 s1_readdata, s2_readdata  out  DATA_WIDTH  read data.
REQ-013 s1_readdatavalid, s2_readdatavalid  out  1  one-cycle qualifier for readdata.
REQ-014 s1_oob_err, s2_oob_err  out  1  one-cycle pulse on an out-of-range access.

Function
REQ-015 Accepted access per port: chipselect & clken & ~reset_req at the rising edge; no waitrequest, every accepted access completes.
REQ-016 Accepted write: update only the byte lanes whose byteenable bit is 1.
REQ-017 Accepted read (read=1, write=0): readdata and readdatavalid=1 exactly LAT cycles later (LAT=1 base, 2 with REQ-027); readdatavalid=0 in every other cycle.
REQ-018 read and write both 1 in one access: treated as write; no readdatavalid.
REQ-019 Per-port read pipeline advances only while that port's clken=1 and reset_req=0; otherwise readdata and readdatavalid hold their values (a held valid is not re-issued when clken returns).
REQ-020 Back-to-back reads on one port every cycle: one result per cycle, in order.
REQ-021 Read-during-write, same port or cross-port, same address, same cycle: the read returns the old data.
REQ-022 Both ports write the same address in the same cycle: s1 wins on each byte lane enabled by both; lanes enabled only by s2 take s2 data.
REQ-023 Address >= DEPTH: write ignored; read returns all-zero data with normal readdatavalid timing; oob_err pulses 1 cycle after acceptance.
REQ-024 Outputs are not combinationally dependent on any input.

Reset
REQ-025 While reset_n=0, and immediately on assertion: readdata=0, readdatavalid=0, oob_err=0; all pipeline stages cleared; in-flight reads discarded, never delivered.
REQ-026 Memory contents are not cleared by reset; only INIT_FILE loads contents (at configuration).

Configuration
REQ-027 Macro ALARM_QSYS_ONCHIP_MEM_OUTREG_EN defined: an extra output register stage per port; LAT=2; oob_err at 2 cycles; readdata changes only on the readdatavalid cycle. Undefined: LAT=1; oob_err at 1 cycle.

Structure
REQ-028 Package alarm_qsys_onchip_mem_pkg SHALL hold LAT_BASE=1, LAT_OUTREG=2, and the byte-lane-count function.
REQ-029 Sub-module alarm_qsys_onchip_memory_dp_ram SHALL hold the behavioural true-dual-port array (byte-enabled, read-old-data); the top holds acceptance, collision resolution, bounds check and valid pipelines.

Verification
REQ-030 s1 write 0xDEADBEEF to addr 5 with be=4'hF, then s2 read addr 5 -> s2_readdata=0xDEADBEEF, s2_readdatavalid=1 exactly LAT cycles after the read.
REQ-031 s1 write addr 7 be=4'b0011 data 0x11223344 over 0xAAAAAAAA -> read addr 7 returns 0xAAAA3344.
REQ-032 Same cycle: s1 writes 0x0000FFFF be=4'h3 and s2 writes 0x12345678 be=4'hF to addr 9 -> addr 9 reads 0x1234FFFF.
REQ-033 s1 read addr 3100 (DEPTH=3072) -> readdata=0, readdatavalid=1 and s1_oob_err=1 pulse; write to 3100 leaves all in-range contents unchanged.
REQ-034 s2 issues 4 back-to-back reads with s2_clken low for 2 cycles mid-stream -> 4 valids in order, outputs held during the stall.
REQ-035 Assert reset_n=0 with a read in flight -> readdatavalid stays 0 after release, memory contents retained.

Source files
------------

// File: rtl/alarm_qsys_onchip_mem_pkg.sv
// -----------------------------------------------------------------------------
// alarm_qsys_onchip_mem_pkg
//
// Shared constants and helpers for the dual-port on-chip memory.
//   LAT_BASE    read latency with no output register stage
//   LAT_OUTREG  read latency with the extra output register stage
//   NUM_PORTS   number of independent access ports (s1, s2)
//   byte_lanes  number of 8-bit lanes in a word
// -----------------------------------------------------------------------------
package alarm_qsys_onchip_mem_pkg;

    localparam int LAT_BASE   = 1;
    localparam int LAT_OUTREG = 2;
    localparam int NUM_PORTS  = 2;

    function automatic int byte_lanes(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/alarm_qsys_onchip_memory_dp_ram.sv
// -----------------------------------------------------------------------------
// alarm_qsys_onchip_memory_dp_ram
//
// Behavioural true-dual-port word array with per-byte write enables and
// registered reads that return the contents from before any same-edge write.
// Contents are never reset; power-up contents come from INIT_FILE, handed to
// the FPGA memory compiler through the ram_init_file attribute.
//
// Ports (a = s1 side, b = s2 side):
//   clk            rising-edge clock
//   a_re, b_re     read enable; q is loaded only when set, otherwise holds
//   a_we, b_we     byte-lane write enables (callers keep overlapping lanes
//                  disjoint when both ports hit the same word)
//   a_addr, b_addr word address (callers only enable for addr < DEPTH)
//   a_wdata,b_wdata write data
//   a_q, b_q       registered read data
// -----------------------------------------------------------------------------
module alarm_qsys_onchip_memory_dp_ram
    import alarm_qsys_onchip_mem_pkg::*;
#(
    parameter int    DATA_WIDTH = 32,
    parameter int    DEPTH      = 3072,
    parameter int    ADDR_WIDTH = 12,
    parameter string INIT_FILE  = "alarm_qsys_onchip_memory_dp.hex"
) (
    input  logic                              clk,
    input  logic                              a_re,
    input  logic [byte_lanes(DATA_WIDTH)-1:0] a_we,
    input  logic [ADDR_WIDTH-1:0]             a_addr,
    input  logic [DATA_WIDTH-1:0]             a_wdata,
    output logic [DATA_WIDTH-1:0]             a_q,
    input  logic                              b_re,
    input  logic [byte_lanes(DATA_WIDTH)-1:0] b_we,
    input  logic [ADDR_WIDTH-1:0]             b_addr,
    input  logic [DATA_WIDTH-1:0]             b_wdata,
    output logic [DATA_WIDTH-1:0]             b_q
);

    localparam int NB = byte_lanes(DATA_WIDTH);

    (* ram_init_file = INIT_FILE *) logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Non-blocking reads sample the array before this edge's writes land,
    // which gives read-old-data for both same-port and cross-port collisions.
    always_ff @(posedge clk) begin
        if (a_re) begin
            a_q <= mem[a_addr];
        end
        if (b_re) begin
            b_q <= mem[b_addr];
        end
        for (int i = 0; i < NB; i++) begin
            if (a_we[i]) begin
                mem[a_addr][i*8 +: 8] <= a_wdata[i*8 +: 8];
            end
            if (b_we[i]) begin
                mem[b_addr][i*8 +: 8] <= b_wdata[i*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/alarm_qsys_onchip_memory_dp.sv
// -----------------------------------------------------------------------------
// alarm_qsys_onchip_memory_dp
//
// Dual-port on-chip memory with byte-enabled writes, bounds checking and a
// read-valid pipeline per port.
//
// Optional build macro: ALARM_QSYS_ONCHIP_MEM_OUTREG_EN adds an output
// register stage per port (read latency 2, oob_err at 2 cycles, readdata only
// changes on a readdatavalid cycle). Without it the read latency is 1.
//
// Ports:
//   clk, reset_n           clock and asynchronous active-low reset
//   reset_req              while high both ports act as if clken were low
//   sN_address             word address
//   sN_chipselect/read/write/clken, sN_byteenable, sN_writedata
//   sN_readdata            read data (0 for out-of-range reads and in reset)
//   sN_readdatavalid       one-cycle qualifier for readdata
//   sN_oob_err             one-cycle pulse after an out-of-range access
//
// Handshake: there is no back-pressure. An access is accepted at a rising
// edge when chipselect & clken & ~reset_req; every accepted access completes.
// read&~write is a read, any access with write=1 is a write. A read result is
// presented with readdatavalid=1 exactly LAT enabled edges later; while a
// port's clken is low (or reset_req high) its readdata/readdatavalid hold.
// -----------------------------------------------------------------------------
module alarm_qsys_onchip_memory_dp
    import alarm_qsys_onchip_mem_pkg::*;
#(
    parameter int    DATA_WIDTH = 32,
    parameter int    DEPTH      = 3072,
    parameter int    ADDR_WIDTH = 12,
    parameter string INIT_FILE  = "alarm_qsys_onchip_memory_dp.hex"
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              reset_req,
    input  logic [ADDR_WIDTH-1:0]             s1_address,
    input  logic                              s1_chipselect,
    input  logic                              s1_read,
    input  logic                              s1_write,
    input  logic                              s1_clken,
    input  logic [byte_lanes(DATA_WIDTH)-1:0] s1_byteenable,
    input  logic [DATA_WIDTH-1:0]             s1_writedata,
    output logic [DATA_WIDTH-1:0]             s1_readdata,
    output logic                              s1_readdatavalid,
    output logic                              s1_oob_err,
    input  logic [ADDR_WIDTH-1:0]             s2_address,
    input  logic                              s2_chipselect,
    input  logic                              s2_read,
    input  logic                              s2_write,
    input  logic                              s2_clken,
    input  logic [byte_lanes(DATA_WIDTH)-1:0] s2_byteenable,
    input  logic [DATA_WIDTH-1:0]             s2_writedata,
    output logic [DATA_WIDTH-1:0]             s2_readdata,
    output logic                              s2_readdatavalid,
    output logic                              s2_oob_err
);

    localparam int NB = byte_lanes(DATA_WIDTH);
`ifdef ALARM_QSYS_ONCHIP_MEM_OUTREG_EN
    localparam int LAT = LAT_OUTREG;
`else
    localparam int LAT = LAT_BASE;
`endif

    // Port 0 is s1, port 1 is s2.
    logic [NUM_PORTS-1:0]  cs, rd, wr, ce;
    logic [ADDR_WIDTH-1:0] addr  [NUM_PORTS];
    logic [NB-1:0]         be    [NUM_PORTS];
    logic [DATA_WIDTH-1:0] wdata [NUM_PORTS];

    assign cs       = {s2_chipselect, s1_chipselect};
    assign rd       = {s2_read, s1_read};
    assign wr       = {s2_write, s1_write};
    assign ce       = {s2_clken, s1_clken};
    assign addr[0]  = s1_address;
    assign addr[1]  = s2_address;
    assign be[0]    = s1_byteenable;
    assign be[1]    = s2_byteenable;
    assign wdata[0] = s1_writedata;
    assign wdata[1] = s2_writedata;

    logic [NUM_PORTS-1:0]  en, acc, rd_acc, wr_acc, in_range, re;
    logic [NB-1:0]         we [NUM_PORTS];
    logic                  same_addr;
    logic [DATA_WIDTH-1:0] q  [NUM_PORTS];

    always_comb begin
        en        = '0;
        acc       = '0;
        rd_acc    = '0;
        wr_acc    = '0;
        in_range  = '0;
        re        = '0;
        we[0]     = '0;
        we[1]     = '0;
        same_addr = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            en[p]       = ce[p] & ~reset_req;
            acc[p]      = cs[p] & en[p];
            in_range[p] = (int'(addr[p]) < DEPTH);
            rd_acc[p]   = acc[p] & rd[p] & ~wr[p];
            wr_acc[p]   = acc[p] & wr[p];
        end
        re        = rd_acc & in_range;
        same_addr = wr_acc[0] & wr_acc[1] & (addr[0] == addr[1]);
        if (wr_acc[0] & in_range[0]) begin
            we[0] = be[0];
        end
        // s1 owns every lane both ports enable on a shared word.
        if (wr_acc[1] & in_range[1]) begin
            we[1] = be[1] & ~(same_addr ? be[0] : '0);
        end
    end

    alarm_qsys_onchip_memory_dp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .INIT_FILE  (INIT_FILE)
    ) u_ram (
        .clk     (clk),
        .a_re    (re[0]),
        .a_we    (we[0]),
        .a_addr  (addr[0]),
        .a_wdata (wdata[0]),
        .a_q     (q[0]),
        .b_re    (re[1]),
        .b_we    (we[1]),
        .b_addr  (addr[1]),
        .b_wdata (wdata[1]),
        .b_q     (q[1])
    );

    logic                  rvalid_o [NUM_PORTS];
    logic                  oob_o    [NUM_PORTS];
    logic [DATA_WIDTH-1:0] rdata_o  [NUM_PORTS];

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        logic                  rd_zero;
        logic                  v1;
        logic                  oob1;
        logic [DATA_WIDTH-1:0] d1;

        // rd_zero masks the unreset RAM register: it forces zero in reset and
        // for out-of-range reads, and tracks the last read's range otherwise.
        // oob1 is a plain pulse and is not held by clken.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                rd_zero <= 1'b1;
                v1      <= 1'b0;
                oob1    <= 1'b0;
            end else begin
                oob1 <= acc[p] & ~in_range[p];
                if (en[p]) begin
                    v1 <= rd_acc[p];
                    if (rd_acc[p]) begin
                        rd_zero <= ~in_range[p];
                    end
                end
            end
        end

        assign d1 = rd_zero ? '0 : q[p];

        if (LAT == LAT_OUTREG) begin : g_outreg
            logic                  v2;
            logic                  oob2;
            logic [DATA_WIDTH-1:0] d2;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    v2   <= 1'b0;
                    oob2 <= 1'b0;
                    d2   <= '0;
                end else begin
                    oob2 <= oob1;
                    if (en[p]) begin
                        v2 <= v1;
                        if (v1) begin
                            d2 <= d1;
                        end
                    end
                end
            end

            assign rvalid_o[p] = v2;
            assign oob_o[p]    = oob2;
            assign rdata_o[p]  = d2;
        end else begin : g_direct
            assign rvalid_o[p] = v1;
            assign oob_o[p]    = oob1;
            assign rdata_o[p]  = d1;
        end
    end

    assign s1_readdata      = rdata_o[0];
    assign s1_readdatavalid = rvalid_o[0];
    assign s1_oob_err       = oob_o[0];
    assign s2_readdata      = rdata_o[1];
    assign s2_readdatavalid = rvalid_o[1];
    assign s2_oob_err       = oob_o[1];

endmodule

// File: tb/tb_alarm_qsys_onchip_memory_dp.sv
// -----------------------------------------------------------------------------
// tb_alarm_qsys_onchip_memory_dp
//
// Drives both ports with directed and random traffic. A word-array model of
// the memory plus per-port result delay lines (advanced only on enabled
// edges) predicts readdata/readdatavalid/oob_err; a compare process checks the
// DUT against it on every falling edge. Directed sections add literal
// expectations for the headline scenarios.
// -----------------------------------------------------------------------------
module tb_alarm_qsys_onchip_memory_dp;

    localparam int W     = 32;
    localparam int DEPTH = 3072;
    localparam int AW    = 12;
    localparam int NB    = W / 8;
`ifdef ALARM_QSYS_ONCHIP_MEM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic reset_req = 1'b0;
    always #5 clk = ~clk;

    // ---------------- stimulus / DUT signals (index 0 = s1, 1 = s2) --------
    logic          cs [2];
    logic          rd [2];
    logic          wr [2];
    logic          ce [2];
    logic [AW-1:0] addr [2];
    logic [NB-1:0] be [2];
    logic [W-1:0]  wd [2];
    logic [W-1:0]  rdata [2];
    logic          rvalid [2];
    logic          oob [2];

    alarm_qsys_onchip_memory_dp #(
        .DATA_WIDTH (W),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .reset_req        (reset_req),
        .s1_address       (addr[0]),
        .s1_chipselect    (cs[0]),
        .s1_read          (rd[0]),
        .s1_write         (wr[0]),
        .s1_clken         (ce[0]),
        .s1_byteenable    (be[0]),
        .s1_writedata     (wd[0]),
        .s1_readdata      (rdata[0]),
        .s1_readdatavalid (rvalid[0]),
        .s1_oob_err       (oob[0]),
        .s2_address       (addr[1]),
        .s2_chipselect    (cs[1]),
        .s2_read          (rd[1]),
        .s2_write         (wr[1]),
        .s2_clken         (ce[1]),
        .s2_byteenable    (be[1]),
        .s2_writedata     (wd[1]),
        .s2_readdata      (rdata[1]),
        .s2_readdatavalid (rvalid[1]),
        .s2_oob_err       (oob[1])
    );

    // ---------------- scoreboard counters ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic         v;
        logic [W-1:0] d;
    } res_t;

    logic [W-1:0] mm [DEPTH];
    res_t         rpipe [2][LAT];
    logic         opipe [2][LAT];
    res_t         m_new [2];
    logic         m_en  [2];
    logic         m_acc [2];
    logic         m_inr [2];
    int           m_a   [2];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int p = 0; p < 2; p++) begin
                for (int s = 0; s < LAT; s++) begin
                    rpipe[p][s] = '0;
                    opipe[p][s] = 1'b0;
                end
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                m_en[p]    = ce[p] && !reset_req;
                m_acc[p]   = cs[p] && m_en[p];
                m_a[p]     = int'(addr[p]);
                m_inr[p]   = m_a[p] < DEPTH;
                m_new[p].v = m_acc[p] && rd[p] && !wr[p];
                m_new[p].d = (m_new[p].v && m_inr[p]) ? mm[m_a[p]] : '0;
                for (int s = LAT - 1; s > 0; s--) opipe[p][s] = opipe[p][s-1];
                opipe[p][0] = m_acc[p] && !m_inr[p];
                if (m_en[p]) begin
                    for (int s = LAT - 1; s > 0; s--) rpipe[p][s] = rpipe[p][s-1];
                    rpipe[p][0] = m_new[p];
                end
            end
            // Reads above saw the old contents. Apply s2 first, then s1, so
            // s1's data ends up on lanes both ports enabled.
            for (int p = 1; p >= 0; p--) begin
                if (m_acc[p] && wr[p] && m_inr[p]) begin
                    for (int b = 0; b < NB; b++) begin
                        if (be[p][b]) mm[m_a[p]][b*8 +: 8] = wd[p][b*8 +: 8];
                    end
                end
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (!reset_n) begin
                check($sformatf("s%0d_valid_in_reset", p + 1), W'(rvalid[p]), '0);
                check($sformatf("s%0d_data_in_reset", p + 1), rdata[p], '0);
                check($sformatf("s%0d_oob_in_reset", p + 1), W'(oob[p]), '0);
            end else begin
                check($sformatf("s%0d_valid", p + 1), W'(rvalid[p]), W'(rpipe[p][LAT-1].v));
                if (rpipe[p][LAT-1].v) begin
                    check($sformatf("s%0d_data", p + 1), rdata[p], rpipe[p][LAT-1].d);
                end
                check($sformatf("s%0d_oob", p + 1), W'(oob[p]), W'(opipe[p][LAT-1]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle();
        reset_req = 1'b0;
        for (int p = 0; p < 2; p++) begin
            cs[p]   = 1'b0;
            rd[p]   = 1'b0;
            wr[p]   = 1'b0;
            ce[p]   = 1'b1;
            addr[p] = '0;
            be[p]   = '0;
            wd[p]   = '0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_lat();
        for (int i = 1; i < LAT; i++) step();
    endtask

    task automatic set_wr(input int p, input int a, input logic [NB-1:0] b, input logic [W-1:0] d);
        cs[p]   = 1'b1;
        wr[p]   = 1'b1;
        rd[p]   = 1'b0;
        addr[p] = AW'(a);
        be[p]   = b;
        wd[p]   = d;
    endtask

    task automatic set_rd(input int p, input int a);
        cs[p]   = 1'b1;
        rd[p]   = 1'b1;
        wr[p]   = 1'b0;
        addr[p] = AW'(a);
    endtask

    // clken stall pattern for the s2 back-to-back read stream
    int           sched_a [8] = '{20, 21, 22, 22, 22, 23, 0, 0};
    bit           sched_r [8] = '{1, 1, 1, 1, 1, 1, 0, 0};
    bit           sched_c [8] = '{1, 1, 0, 0, 1, 1, 1, 1};
    logic [W-1:0] got [$];

    // ---------------- main sequence ----------------
    initial begin
        idle();
        reset_n = 1'b0;
        repeat (3) step();
        check("rst_s1_valid", W'(rvalid[0]), '0);
        check("rst_s1_data", rdata[0], '0);
        check("rst_s2_oob", W'(oob[1]), '0);
        reset_n = 1'b1;
        step();

        // Fill every word so the model is fully known.
        for (int a = 0; a < DEPTH; a += 2) begin
            idle();
            set_wr(0, a, {NB{1'b1}}, $urandom);
            set_wr(1, a + 1, {NB{1'b1}}, $urandom);
            step();
        end

        // Write on s1, read on s2.
        idle(); set_wr(0, 5, 4'hF, 32'hDEADBEEF); step();
        idle(); set_rd(1, 5); step(); idle(); wait_lat();
        check("req030_data", rdata[1], 32'hDEADBEEF);
        check("req030_valid", W'(rvalid[1]), 1);

        // Partial byte write.
        idle(); set_wr(0, 7, 4'hF, 32'hAAAAAAAA); step();
        idle(); set_wr(0, 7, 4'b0011, 32'h11223344); step();
        idle(); set_rd(0, 7); step(); idle(); wait_lat();
        check("req031_data", rdata[0], 32'hAAAA3344);

        // Same-word collision, s1 wins shared lanes.
        idle(); set_wr(0, 9, 4'h3, 32'h0000FFFF); set_wr(1, 9, 4'hF, 32'h12345678); step();
        idle(); set_rd(0, 9); step(); idle(); wait_lat();
        check("req032_data", rdata[0], 32'h1234FFFF);

        // Cross-port read-during-write returns old data.
        idle(); set_wr(0, 11, 4'hF, 32'h01010101); step();
        idle(); set_wr(0, 11, 4'hF, 32'h02020202); set_rd(1, 11); step(); idle(); wait_lat();
        check("rdw_old_data", rdata[1], 32'h01010101);
        idle(); set_rd(0, 11); step(); idle(); wait_lat();
        check("rdw_new_data", rdata[0], 32'h02020202);

        // Out-of-range read and write.
        idle(); set_rd(0, 3100); step(); idle(); wait_lat();
        check("req033_data", rdata[0], '0);
        check("req033_valid", W'(rvalid[0]), 1);
        check("req033_oob", W'(oob[0]), 1);
        step();
        check("req033_oob_pulse_end", W'(oob[0]), '0);
        idle(); set_wr(1, 3100, 4'hF, 32'hCAFEF00D); step();
        for (int a = 0; a < DEPTH; a += 2) begin
            idle(); set_rd(0, a); set_rd(1, a + 1); step();
        end
        idle(); repeat (LAT + 1) step();

        // s2 back-to-back reads with a two-cycle clken stall.
        for (int i = 0; i < 4; i++) begin
            idle(); set_wr(0, 20 + i, 4'hF, W'(32'h100 + i)); step();
        end
        got.delete();
        for (int i = 0; i < 8; i++) begin
            idle();
            ce[1] = sched_c[i];
            if (sched_r[i]) set_rd(1, sched_a[i]);
            step();
            if (sched_c[i] && rvalid[1]) got.push_back(rdata[1]);
        end
        check("req034_count", W'(got.size()), 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("req034_order%0d", i), (i < got.size()) ? got[i] : 'x, W'(32'h100 + i));
        end

        // Random traffic in a narrow window to force collisions.
        for (int n = 0; n < 2000; n++) begin
            idle();
            reset_req = ($urandom_range(0, 15) == 0);
            for (int p = 0; p < 2; p++) begin
                ce[p]   = ($urandom_range(0, 7) != 0);
                cs[p]   = ($urandom_range(0, 3) != 0);
                rd[p]   = ($urandom_range(0, 1) == 1);
                wr[p]   = ($urandom_range(0, 2) == 0);
                addr[p] = ($urandom_range(0, 19) == 0) ? AW'(DEPTH + $urandom_range(0, 40))
                                                       : AW'(32 + $urandom_range(0, 7));
                be[p]   = NB'($urandom_range(0, 15));
                wd[p]   = $urandom;
            end
            step();
        end
        idle(); repeat (LAT + 1) step();

        // Reset with a read in flight.
        idle(); set_rd(0, 5); step(); idle();
        reset_n = 1'b0;
        step();
        check("req035_valid_in_reset", W'(rvalid[0]), '0);
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("req035_no_late_valid%0d", i), W'(rvalid[0]), '0);
        end
        idle(); set_rd(0, 5); step(); idle(); wait_lat();
        check("req035_retained5", rdata[0], 32'hDEADBEEF);
        idle(); set_rd(1, 7); step(); idle(); wait_lat();
        check("req035_retained7", rdata[1], 32'hAAAA3344);
        idle(); repeat (LAT + 1) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog");
    end

endmodule
